npu_job_scheduler: RTL and testbench
====================================

// Module: npu_job_scheduler
// PURPOSE
//  Round-robin job scheduler in front of npu_fsm_top. It shares one NPU datapath between NREQ requesters.
//  Per job: accept one operand set, hold it on the NPU inputs, pulse START, await DONE (with watchdog),
//  then return D_OUT to the requester, tagged with requester ID and an error flag.
// PARAMETERS
//  NREQ     2   number of requesters (2..8)
//  TIMEOUT  64  max cycles in WAIT before the job is aborted with RSP_ERR=1 (>=2)
//  ID_W     1   width of RSP_ID; must equal clog2(NREQ)
// PORTS
//  CLKEXT         in   1        single clock, rising edge
//  RST_GLO        in   1        reset, asynchronous, active-low
//  REQ_VALID      in   NREQ     per-requester job valid
//  REQ_READY      out  NREQ     per-requester accept (one-hot or zero)
//  REQ_OPS        in   NREQ*40  per requester {BIAS,DD,DC,DB,DA}; requester i at [40*i +: 40]
//  REQ_SSFR       in   NREQ*16  per-requester SSFR config; requester i at [16*i +: 16]
//  NPU_START      out  1        one-cycle start pulse to NPU
//  NPU_OPS        out  40       latched {BIAS,DD,DC,DB,DA} to NPU
//  NPU_SSFR       out  16       latched SSFR to NPU
//  NPU_DONE       in   1        NPU completion flag
//  NPU_DOUT       in   8        NPU result (D_OUT)
//  NPU_FIFO_FULL  in   1        NPU output FIFO full; blocks issue
//  RSP_VALID      out  1        response valid
//  RSP_READY      in   1        response accept
//  RSP_ID         out  ID_W     requester index of response
//  RSP_DATA       out  8        result (0 on error)
//  RSP_ERR        out  1        1 = watchdog timeout
//  SCHED_BUSY     out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset (RST_GLO=0, async): state=IDLE; all outputs and latches 0; rr_ptr=NREQ-1, so requester 0 wins first.
//  Reset mid-job: job dropped, no response, NPU_START low immediately.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if any REQ_VALID and !NPU_FIFO_FULL:
//    - grant g = first valid index searching from (rr_ptr+1) mod NREQ upward with wrap.
//    - REQ_READY[g]=1 for that cycle only (combinational on REQ_VALID).
//    - on the edge, latch REQ_OPS[g], REQ_SSFR[g] and g; go ISSUE.
//    - If NPU_FIFO_FULL, REQ_READY=0 and stay in IDLE.
//   ISSUE: NPU_START=1 for exactly this cycle; watchdog cleared; go WAIT.
//   WAIT: NPU_DONE=1 -> latch NPU_DOUT into RSP_DATA, RSP_ERR=0, go RESP.
//    - Otherwise the watchdog increments.
//    - watchdog==TIMEOUT-1 without DONE -> RSP_DATA=0, RSP_ERR=1, go RESP.
//    - DONE and timeout in the same cycle: DONE wins.
//   RESP: RSP_VALID=1; RSP_ID/DATA/ERR stable until RSP_READY=1.
//    - On the handshake edge: rr_ptr=g, go IDLE.
//  NPU_DONE outside WAIT is ignored.
//  NPU_OPS/NPU_SSFR hold the latched values from ISSUE through RESP. They change only on acceptance.
//  Latency, acceptance edge = T0: NPU_START high in cycle T1; WAIT from T2.
//   DONE sampled at Tk -> RSP_VALID from Tk+1.
//   With RSP_READY tied high, back-to-back jobs have 1 IDLE cycle between responses.
//  Fairness: a continuously valid requester waits at most NREQ-1 jobs.
//  Watchdog width: clog2(TIMEOUT); no wrap, saturates at TIMEOUT-1 by construction.
// STRUCTURE
//  npu_defs.vh: state encodings, OPS_W=40, field offsets DA=0, DB=8, DC=16, DD=24, BIAS=32, SSFR_W=16.
//  Sub-module npu_rr_arbiter (NREQ):
//   - inputs req, ptr, en; outputs one-hot grant and encoded index; purely combinational.
//   - rr_ptr register stays in the scheduler.
//  Scheduler holds the FSM, operand/SSFR latches, watchdog and response registers.
// TESTING (behavioural NPU model: DONE pulses N cycles after START, DOUT=(DA*DB+DC*DD+BIAS) mod 256)
//  1. req0 DA=3 DB=4 DC=2 DD=5 BIAS=1, N=3
//     -> NPU_START 1 cycle after accept; RSP_VALID 4 cycles after START; RSP_ID=0 RSP_DATA=23 RSP_ERR=0.
//  2. req0 and req1 both valid continuously, 4 jobs, RSP_READY=1
//     -> grant order 0,1,0,1; no START overlap; SCHED_BUSY low exactly 1 cycle between jobs.
//  3. Model never asserts DONE, TIMEOUT=64
//     -> RSP_ERR=1, RSP_DATA=0, RSP_VALID exactly 64 cycles after entering WAIT; next job accepted afterwards.
//  4. RSP_READY held low 10 cycles in RESP
//     -> RSP_* stable throughout; REQ_READY=0; new REQ_VALID not accepted until handshake.
//  5. NPU_FIFO_FULL=1 with req1 valid -> REQ_READY=0, no START; drop FULL -> accept next cycle.
//  6. RST_GLO low for 2 cycles during WAIT
//     -> all outputs 0 asynchronously; no response for the aborted job; rr_ptr restarts with requester 0.

Source files
------------

// File: rtl/npu_job_scheduler_pkg.sv
// Shared definitions for the NPU job scheduler: operand layout, widths and FSM states.
`timescale 1ns/1ps
package npu_job_scheduler_pkg;

    // Operand bundle layout {BIAS,DD,DC,DB,DA}, one byte per field
    localparam int OPS_W    = 40;
    localparam int SSFR_W   = 16;
    localparam int DOUT_W   = 8;
    localparam int FIELD_W  = 8;
    localparam int DA_OFF   = 0;
    localparam int DB_OFF   = 8;
    localparam int DC_OFF   = 16;
    localparam int DD_OFF   = 24;
    localparam int BIAS_OFF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    // Extract one byte-wide operand field from a packed operand bundle
    function automatic logic [FIELD_W-1:0] ops_field(input logic [OPS_W-1:0] ops, input int off);
        return ops[off +: FIELD_W];
    endfunction

endpackage

// File: rtl/npu_job_scheduler_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr+1 (with wrap) wins.
`timescale 1ns/1ps
module npu_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] index
);

    // One extra bit so ptr+offset never overflows before the modulo fold
    localparam int SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0] NREQ_S = SUM_W'(NREQ);

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk offsets 1..NREQ from the last winner; the first valid requester takes the grant
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, ptr} + SUM_W'(k);
            if (sum >= NREQ_S) begin
                sum = sum - NREQ_S;
            end
            cand = sum[IDX_W-1:0];
            if (en && !found && req[cand]) begin
                grant[cand] = 1'b1;
                index       = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/npu_job_scheduler.sv
// Round-robin job scheduler sharing one NPU datapath between NREQ requesters.
// One job at a time: accept, pulse START, wait for DONE under a watchdog, return the result.
`timescale 1ns/1ps
module npu_job_scheduler
    import npu_job_scheduler_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    parameter int ID_W    = 1
) (
    input  logic                     CLKEXT,
    input  logic                     RST_GLO,
    input  logic [NREQ-1:0]          REQ_VALID,
    output logic [NREQ-1:0]          REQ_READY,
    input  logic [NREQ*OPS_W-1:0]    REQ_OPS,
    input  logic [NREQ*SSFR_W-1:0]   REQ_SSFR,
    output logic                     NPU_START,
    output logic [OPS_W-1:0]         NPU_OPS,
    output logic [SSFR_W-1:0]        NPU_SSFR,
    input  logic                     NPU_DONE,
    input  logic [DOUT_W-1:0]        NPU_DOUT,
    input  logic                     NPU_FIFO_FULL,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [ID_W-1:0]          RSP_ID,
    output logic [DOUT_W-1:0]        RSP_DATA,
    output logic                     RSP_ERR,
    output logic                     SCHED_BUSY
);

    // Watchdog only needs to reach TIMEOUT-1, so it never wraps
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    sched_state_t        state_reg;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic [ID_W-1:0]     gid_reg;
    logic [OPS_W-1:0]    ops_reg;
    logic [SSFR_W-1:0]   ssfr_reg;
    logic [WD_W-1:0]     wd_reg;
    logic                npu_start_reg;
    logic                rsp_valid_reg;
    logic [DOUT_W-1:0]   rsp_data_reg;
    logic                rsp_err_reg;

    logic [OPS_W-1:0]    req_ops_arr  [NREQ];
    logic [SSFR_W-1:0]   req_ssfr_arr [NREQ];
    logic [NREQ-1:0]     arb_grant;
    logic [ID_W-1:0]     arb_index;
    logic                arb_en;
    logic                accept;

    // Split the flat request buses into per-requester slices
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_ops_arr[gi]  = REQ_OPS[OPS_W*gi +: OPS_W];
            assign req_ssfr_arr[gi] = REQ_SSFR[SSFR_W*gi +: SSFR_W];
        end
    endgenerate

    // Arbitration is only live in IDLE with room downstream; reset also masks the grant
    assign arb_en = RST_GLO && (state_reg == ST_IDLE) && !NPU_FIFO_FULL;

    npu_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req   (REQ_VALID),
        .ptr   (rr_ptr_reg),
        .en    (arb_en),
        .grant (arb_grant),
        .index (arb_index)
    );

    assign accept     = |arb_grant;
    assign REQ_READY  = arb_grant;
    assign NPU_START  = npu_start_reg;
    assign NPU_OPS    = ops_reg;
    assign NPU_SSFR   = ssfr_reg;
    assign RSP_VALID  = rsp_valid_reg;
    assign RSP_ID     = gid_reg;
    assign RSP_DATA   = rsp_data_reg;
    assign RSP_ERR    = rsp_err_reg;
    assign SCHED_BUSY = (state_reg != ST_IDLE);

    // Job FSM: accept -> start pulse -> wait/watchdog -> hold response until taken
    always_ff @(posedge CLKEXT or negedge RST_GLO) begin
        if (!RST_GLO) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= ID_W'(NREQ - 1);
            gid_reg       <= '0;
            ops_reg       <= '0;
            ssfr_reg      <= '0;
            wd_reg        <= '0;
            npu_start_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        ops_reg       <= req_ops_arr[arb_index];
                        ssfr_reg      <= req_ssfr_arr[arb_index];
                        gid_reg       <= arb_index;
                        npu_start_reg <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    npu_start_reg <= 1'b0;
                    wd_reg        <= '0;
                    state_reg     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // DONE takes priority over an expiring watchdog in the same cycle
                    if (NPU_DONE) begin
                        rsp_data_reg  <= NPU_DOUT;
                        rsp_err_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end else if (wd_reg == WD_LAST) begin
                        rsp_data_reg  <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_reg <= 1'b0;
                        rr_ptr_reg    <= gid_reg;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_job_scheduler.sv
// Scoreboard bench for npu_job_scheduler with a behavioural NPU (DONE N cycles after START).
`timescale 1ns/1ps
module tb_npu_job_scheduler;
    import npu_job_scheduler_pkg::*;

    localparam int NREQ = 2;
    localparam int ID_W = 1;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*OPS_W-1:0]  req_ops;
    logic [NREQ*SSFR_W-1:0] req_ssfr;
    logic                   npu_start;
    logic [OPS_W-1:0]       npu_ops;
    logic [SSFR_W-1:0]      npu_ssfr;
    logic                   npu_done;
    logic [7:0]             npu_dout;
    logic                   fifo_full;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [7:0]             rsp_data;
    logic                   rsp_err;
    logic                   sched_busy;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [7:0]      data;
        logic            err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // behavioural NPU controls/state
    logic       npu_hang;
    int         npu_n;
    logic       m_active;
    int         m_cnt;
    logic [7:0] m_dout;

    npu_job_scheduler #(.NREQ(NREQ), .TIMEOUT(64), .ID_W(ID_W)) dut (
        .CLKEXT        (clk),
        .RST_GLO       (rst_n),
        .REQ_VALID     (req_valid),
        .REQ_READY     (req_ready),
        .REQ_OPS       (req_ops),
        .REQ_SSFR      (req_ssfr),
        .NPU_START     (npu_start),
        .NPU_OPS       (npu_ops),
        .NPU_SSFR      (npu_ssfr),
        .NPU_DONE      (npu_done),
        .NPU_DOUT      (npu_dout),
        .NPU_FIFO_FULL (fifo_full),
        .RSP_VALID     (rsp_valid),
        .RSP_READY     (rsp_ready),
        .RSP_ID        (rsp_id),
        .RSP_DATA      (rsp_data),
        .RSP_ERR       (rsp_err),
        .SCHED_BUSY    (sched_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] calc(input logic [OPS_W-1:0] ops);
        int r;
        r = ops_field(ops, DA_OFF) * ops_field(ops, DB_OFF)
          + ops_field(ops, DC_OFF) * ops_field(ops, DD_OFF)
          + ops_field(ops, BIAS_OFF);
        return 8'(r % 256);
    endfunction

    function automatic logic [OPS_W-1:0] pack(input logic [7:0] da, input logic [7:0] db,
                                              input logic [7:0] dc, input logic [7:0] dd,
                                              input logic [7:0] bias);
        return {bias, dd, dc, db, da};
    endfunction

    task automatic set_ops(input int r, input logic [OPS_W-1:0] ops);
        req_ops[OPS_W*r +: OPS_W] = ops;
    endtask

    task automatic push_exp(input logic [ID_W-1:0] id, input logic [7:0] data, input logic err);
        exp_t e;
        e.id = id; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    // count negedges until RSP_VALID, bounded
    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!rsp_valid) check("rsp_wait_expired", 64'd0, 64'd1);
    endtask

    // behavioural NPU: DONE pulses npu_n cycles after START, unless hung
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            npu_done <= 1'b0;
            npu_dout <= 8'd0;
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_dout   <= 8'd0;
        end else begin
            npu_done <= 1'b0;
            if (npu_start) begin
                m_active <= 1'b1;
                m_cnt    <= npu_n - 1;
                m_dout   <= calc(npu_ops);
            end else if (m_active && !npu_hang) begin
                if (m_cnt <= 1) begin
                    npu_done <= 1'b1;
                    npu_dout <= m_dout;
                    m_active <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // response monitor: pop and compare on every handshake
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            $display("rsp id=%0d data=%0d err=%0d", rsp_id, rsp_data, rsp_err);
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    int cyc, n, starts, idle_run;
    logic dropped;
    logic [1:0] gexp [4];
    logic [OPS_W-1:0] ops_a, ops_b, ops_c, ops_d, ops_e;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_ops = '0; req_ssfr = '0;
        fifo_full = 1'b0; rsp_ready = 1'b1; npu_hang = 1'b0; npu_n = 3;
        ops_a = pack(8'd3, 8'd4, 8'd2, 8'd5, 8'd1);       // 23
        ops_b = pack(8'd10, 8'd2, 8'd3, 8'd4, 8'd5);      // 37
        ops_c = pack(8'd100, 8'd3, 8'd7, 8'd9, 8'd200);   // 563 mod 256 = 51
        ops_d = pack(8'd9, 8'd9, 8'd9, 8'd9, 8'd9);       // 171
        ops_e = pack(8'd7, 8'd7, 8'd1, 8'd1, 8'd0);       // 50

        // reset state, including a request held during reset
        req_valid = 2'b01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_start", 64'(npu_start), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(sched_busy), 64'd0);
        check("rst_ops", 64'(npu_ops), 64'd0);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b1;

        // 1: single job from requester 0, latency and result
        @(posedge clk); #1;
        set_ops(0, ops_a);
        req_ssfr[15:0] = 16'hA5A5;
        push_exp(1'b0, 8'd23, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        check("t1_ready", 64'(req_ready), 64'd1);
        check("t1_start_pre", 64'(npu_start), 64'd0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("t1_start", 64'(npu_start), 64'd1);
        check("t1_ops", 64'(npu_ops), 64'(ops_a));
        check("t1_ssfr", 64'(npu_ssfr), 64'hA5A5);
        wait_rsp(cyc);
        check("t1_latency", 64'(cyc), 64'd4);
        @(posedge clk); #1;

        // 2: fresh reset, both requesters continuously valid, four jobs
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        set_ops(0, ops_b);
        set_ops(1, ops_c);
        gexp[0] = 2'b01; gexp[1] = 2'b10; gexp[2] = 2'b01; gexp[3] = 2'b10;
        push_exp(1'b0, 8'd37, 1'b0);
        push_exp(1'b1, 8'd51, 1'b0);
        push_exp(1'b0, 8'd37, 1'b0);
        push_exp(1'b1, 8'd51, 1'b0);
        req_valid = 2'b11;
        n = 0; starts = 0; idle_run = 0; dropped = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (npu_start) starts++;
            if (sched_busy) begin
                if (n >= 2 && idle_run > 0) check("t2_idle_gap", 64'(idle_run), 64'd1);
                idle_run = 0;
            end else begin
                idle_run++;
            end
            if (req_ready != '0) begin
                if (n < 4) check("t2_grant", 64'(req_ready), 64'(gexp[n]));
                n++;
            end
            if (n >= 4 && !dropped) begin
                @(posedge clk); #1;
                req_valid = '0;
                dropped = 1'b1;
            end else if (n >= 4 && sb.size() == 0 && !sched_busy) begin
                break;
            end
        end
        check("t2_jobs", 64'(n), 64'd4);
        check("t2_starts", 64'(starts), 64'd4);

        // 3: NPU never answers -> watchdog error after 64 WAIT cycles
        @(posedge clk); #1;
        npu_hang = 1'b1;
        set_ops(1, ops_d);
        push_exp(1'b1, 8'd0, 1'b1);
        req_valid = 2'b10;
        @(negedge clk);
        check("t3_ready", 64'(req_ready), 64'd2);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("t3_start", 64'(npu_start), 64'd1);
        wait_rsp(cyc);
        check("t3_wd_latency", 64'(cyc - 1), 64'd64);
        @(posedge clk); #1;

        // 4: next job accepted; response held 10 cycles with RSP_READY low
        npu_hang = 1'b0;
        rsp_ready = 1'b0;
        set_ops(0, ops_e);
        push_exp(1'b0, 8'd50, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        check("t4_accept_after_wd", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(cyc);
        @(posedge clk); #1;
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 64'(rsp_valid), 64'd1);
            check("t4_hold_data", 64'(rsp_data), 64'd50);
            check("t4_hold_id", 64'(rsp_id), 64'd0);
            check("t4_hold_ready", 64'(req_ready), 64'd0);
            check("t4_hold_ops", 64'(npu_ops), 64'(ops_e));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        push_exp(1'b1, 8'd171, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_next_grant", 64'(req_ready), 64'd2);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(cyc);
        @(posedge clk); #1;

        // 5: FIFO full blocks issue; dropping it lets the request in
        fifo_full = 1'b1;
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_full_ready", 64'(req_ready), 64'd0);
            check("t5_full_start", 64'(npu_start), 64'd0);
            check("t5_full_busy", 64'(sched_busy), 64'd0);
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        @(negedge clk);
        check("t5_accept", 64'(req_ready), 64'd2);
        push_exp(1'b1, 8'd171, 1'b0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("t5_start", 64'(npu_start), 64'd1);
        wait_rsp(cyc);
        @(posedge clk); #1;

        // 6: reset during WAIT drops the job and restarts the round robin at 0
        npu_hang = 1'b1;
        set_ops(0, ops_a);
        req_valid = 2'b01;
        @(negedge clk);
        check("t6_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("t6_in_wait", 64'(sched_busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_busy", 64'(sched_busy), 64'd0);
        check("t6_async_start", 64'(npu_start), 64'd0);
        check("t6_async_ops", 64'(npu_ops), 64'd0);
        check("t6_async_rsp", 64'(rsp_valid), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        npu_hang = 1'b0;
        set_ops(0, ops_b);
        req_valid = 2'b11;
        @(negedge clk);
        check("t6_rr_restart", 64'(req_ready), 64'd1);
        push_exp(1'b0, 8'd37, 1'b0);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(cyc);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
